mstd_sequencer: RTL and testbench



---
 rtl/mstd_sequencer_pkg.sv | 31 +++
 rtl/mstd_sequencer_iter_step.sv | 34 +++
 rtl/mstd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mstd_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mstd_sequencer_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: FSM states,
// FUNCT3 operation codes, the decode ALU code and the latched-operation record.
package mstd_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [3:0] ALU_MSTD = 4'd11;

  typedef struct packed {
    logic [2:0] funct3;
    logic       sign_a;
    logic       sign_b;
  } mstd_op_t;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/mstd_sequencer_iter_step.sv
// One combinational iteration of the shared datapath: shift-add multiply step
// or restoring-divide step on the 2*XLEN accumulator.
module mstd_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          ge;

  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    // A set top bit of the shifted remainder already exceeds any divisor.
    trial   = {1'b0, rem_sh[XLEN-1:0]} - {1'b0, opnd_i};
    ge      = rem_sh[XLEN] | ~trial[XLEN];
    acc_o   = '0;
    q_bit_o = 1'b0;
    if (is_div_i) begin
      acc_o   = {(ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
      q_bit_o = ge;
    end else begin
      acc_o = {(acc_i[0] ? add_sum : {1'b0, acc_i[2*XLEN-1:XLEN]}), acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mstd_sequencer.sv
// Multi-cycle RV32M multiply/divide controller (IDLE/RUN/FIX/DONE).
// Define MSTD_EARLY_OUT_EN to let multiplies leave RUN once the multiplier is exhausted.
module mstd_sequencer
  import mstd_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OP_A,
  input  logic [XLEN-1:0] OP_B,
  input  logic            KILL,
  output logic            STALL,
  output logic            RESULT_VALID,
  output logic [XLEN-1:0] RESULT
);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mstd_op_t          op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  logic              is_div_req, signed_a, signed_b, neg_a, neg_b;
  logic              b_zero, ovf, fast, accept, prod_neg;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res, fix_res;
  logic [2*XLEN-1:0] step_acc, acc_step, prod_fix;
  logic              step_q;

  always_comb begin
    is_div_req = f3_is_div(FUNCT3);
    signed_a   = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_MULHSU) ||
                 (FUNCT3 == F3_DIV)  || (FUNCT3 == F3_REM);
    signed_b   = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
    neg_a      = signed_a & OP_A[XLEN-1];
    neg_b      = signed_b & OP_B[XLEN-1];
    mag_a      = cond_neg(OP_A, neg_a);
    mag_b      = cond_neg(OP_B, neg_b);
    accept     = (state_q == ST_IDLE) && START && !KILL;
    b_zero     = (OP_B == '0);
    ovf        = ((FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM)) &&
                 (OP_A == {1'b1, {(XLEN-1){1'b0}}}) && (OP_B == '1);
    fast       = is_div_req && (b_zero || ovf);
    // FUNCT3[1] distinguishes rem/remu from div/divu.
    if (b_zero) fast_res = FUNCT3[1] ? OP_A : '1;
    else        fast_res = FUNCT3[1] ? '0 : OP_A;
  end

  mstd_iter_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q.funct3[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .q_bit_o  (step_q)
  );

  assign acc_step = {step_acc[2*XLEN-1:1], step_acc[0] | step_q};

`ifdef MSTD_EARLY_OUT_EN
  logic [XLEN-1:0] rem_mask;
  logic            early;
  always_comb begin
    rem_mask = (XLEN'(1) << (cnt_q - CNT_W'(1))) - XLEN'(1);
    early    = !op_q.funct3[2] && ((acc_step[XLEN-1:0] & rem_mask) == '0);
  end
`endif

  always_comb begin
    prod_neg = op_q.sign_a ^ op_q.sign_b;
    prod_fix = prod_neg ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    case (op_q.funct3)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = cond_neg(acc_q[XLEN-1:0], prod_neg);
      F3_REM, F3_REMU:              fix_res = cond_neg(acc_q[2*XLEN-1:XLEN], op_q.sign_a);
      default:                      fix_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        op_d.funct3 = FUNCT3;
        op_d.sign_a = neg_a;
        op_d.sign_b = neg_b;
        // Multiplier (B) or dividend (A) sits in the low half; the other operand is fixed.
        acc_d  = {{XLEN{1'b0}}, (is_div_req ? mag_a : mag_b)};
        opnd_d = is_div_req ? mag_b : mag_a;
        cnt_d  = CNT_W'(XLEN);
        if (fast) begin
          result_d = fast_res;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (KILL) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
`ifdef MSTD_EARLY_OUT_EN
          if (early) begin
            acc_d   = acc_step >> (cnt_q - CNT_W'(1));
            state_d = ST_FIX;
          end
`endif
        end
      end
      ST_FIX: begin
        if (KILL) begin
          state_d = ST_IDLE;
        end else begin
          result_d = fix_res;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign STALL        = !RST && (accept || (state_q == ST_RUN) || (state_q == ST_FIX));
  assign RESULT_VALID = valid_q;
  assign RESULT       = result_q;

endmodule

// File: tb/tb_mstd_sequencer.sv
// Self-checking bench for mstd_sequencer: an arithmetic reference model drives
// per-cycle STALL/RESULT_VALID/RESULT expectations, pinned by literal results.
module tb_mstd_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, KILL;
  logic [2:0]  FUNCT3;
  logic [31:0] OP_A, OP_B;
  logic        STALL, RESULT_VALID;
  logic [31:0] RESULT;

  mstd_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .FUNCT3       (FUNCT3),
    .OP_A         (OP_A),
    .OP_B         (OP_B),
    .KILL         (KILL),
    .STALL        (STALL),
    .RESULT_VALID (RESULT_VALID),
    .RESULT       (RESULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          t_acc   = -1;
  int          t_end   = -1;
  int          t_valid = -1;
  int          lit_lat = 0;
  int          chk_cyc = -1;
  logic [31:0] m_res, lit_res, chk_val, last_res;
  bit          eo_on;

  // RISC-V M-extension semantics computed with 64-bit host arithmetic.
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic [63:0]     pb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'b000: begin p = sa * sb; pb = p; return pb[31:0]; end
      3'b001: begin p = sa * sb; pb = p; return pb[63:32]; end
      3'b010: begin p = sa * longint'(ub); pb = p; return pb[63:32]; end
      3'b011: begin up = ua * ub; pb = up; return pb[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; pb = p; return pb[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFFFFFF;
        up = ua / ub; pb = up; return pb[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; pb = p; return pb[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; pb = up; return pb[31:0];
      end
    endcase
  endfunction

  // Cycles from accept to the result pulse.
  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    n = 32;
`ifdef MSTD_EARLY_OUT_EN
    if (!f[2]) begin
      logic [31:0] mb;
      mb = (f == 3'b001 && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
    end
`endif
    return n + 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    chk("STALL", 32'(STALL), 32'(!RST && t_acc >= 0 && cyc >= t_acc && cyc <= t_end));
    chk("RESULT_VALID", 32'(RESULT_VALID), 32'(!RST && cyc == t_valid));
    if (!RST && cyc == t_valid) begin
      chk("RESULT_vs_model", RESULT, m_res);
      chk("RESULT_vs_literal", RESULT, lit_res);
      chk("latency_vs_literal", 32'(t_valid - t_acc), 32'(lit_lat));
    end
    if (cyc == chk_cyc) chk("RESULT_hold", RESULT, chk_val);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] lit, input int llat);
    tick();
    START = 1'b1; FUNCT3 = f; OP_A = a; OP_B = b;
    m_res   = model_res(f, a, b);
    lit_res = lit;
    lit_lat = llat;
    t_acc   = cyc;
    t_valid = cyc + model_lat(f, a, b);
    t_end   = t_valid - 1;
    tick();
    START = 1'b0;
    while (cyc <= t_valid) tick();
    last_res = m_res;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; KILL = 1'b0; FUNCT3 = 3'b000; OP_A = '0; OP_B = '0;
`ifdef MSTD_EARLY_OUT_EN
    eo_on = 1'b1;
`else
    eo_on = 1'b0;
`endif
    repeat (2) tick();
    START = 1'b1; OP_A = 32'd9; OP_B = 32'd3;
    tick();
    START = 1'b0;
    RST = 1'b0;
    chk_cyc = cyc; chk_val = 32'h0; last_res = 32'h0;
    tick();

    op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, eo_on ? 3 : 34);
    op(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, eo_on ? 4 : 34);
    op(3'b000, 32'd123,      32'd1,        32'd123,      eo_on ? 3 : 34);
    op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    op(3'b000, 32'd0,        32'd0,        32'd0,        eo_on ? 3 : 34);
    op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    op(3'b101, 32'd100,      32'd7,        32'd14,       34);
    op(3'b111, 32'd100,      32'd7,        32'd2,        34);
    op(3'b101, 32'hFFFFFFFF, 32'h80000001, 32'd1,        34);
    op(3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 34);
    op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op(3'b110, 32'd5,        32'd0,        32'd5,        1);
    op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op(3'b111, 32'd5,        32'd0,        32'd5,        1);
    op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush a divide in its tenth cycle, then issue a fresh one.
    tick();
    START = 1'b1; FUNCT3 = 3'b100; OP_A = 32'd1000; OP_B = 32'd3;
    t_acc = cyc; t_end = cyc + 10; t_valid = -1;
    tick();
    START = 1'b0;
    while (cyc < t_acc + 10) tick();
    KILL = 1'b1;
    tick();
    KILL = 1'b0;
    chk_cyc = cyc; chk_val = last_res;
    op(3'b101, 32'd100, 32'd7, 32'd14, 34);

    // START together with KILL in IDLE is not accepted.
    tick();
    START = 1'b1; KILL = 1'b1; FUNCT3 = 3'b000; OP_A = 32'd5; OP_B = 32'd5;
    tick();
    START = 1'b0; KILL = 1'b0;
    chk_cyc = cyc + 2; chk_val = last_res;
    repeat (4) tick();

    // Reset mid-operation: no pulse, result cleared.
    tick();
    START = 1'b1; FUNCT3 = 3'b000; OP_A = 32'd3; OP_B = 32'd5;
    t_acc = cyc; t_end = cyc + 4; t_valid = -1;
    tick();
    START = 1'b0;
    while (cyc < t_acc + 5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_cyc = cyc; chk_val = 32'h0; last_res = 32'h0;
    repeat (3) tick();
    op(3'b000, 32'd6, 32'd7, 32'd42, eo_on ? 5 : 34);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
